// File: rtl/pic_host_controller_if.sv
// ============================================================================
// pic_host_controller_if : PIC-side bus (strobes, A0, split data bus, INT)
// Revision: 1.0
// ============================================================================
`default_nettype none

interface pic_host_controller_if;
    logic       pic_int;
    logic       pic_cs_n;
    logic       pic_wr_n;
    logic       pic_rd_n;
    logic       pic_inta_n;
    logic       pic_a0;
    logic [7:0] pic_data_out;
    logic       pic_data_oe;
    logic [7:0] pic_data_in;

    modport master (
        input  pic_int, pic_data_in,
        output pic_cs_n, pic_wr_n, pic_rd_n, pic_inta_n, pic_a0,
               pic_data_out, pic_data_oe
    );

    modport slave (
        output pic_int, pic_data_in,
        input  pic_cs_n, pic_wr_n, pic_rd_n, pic_inta_n, pic_a0,
               pic_data_out, pic_data_oe
    );
endinterface

`default_nettype wire

// File: rtl/pic_host_controller.sv
// ============================================================================
// pic_host_controller : host bus master for an 8259 PIC (init, OCW/status, INTA)
// Revision: 1.0
// ============================================================================
`default_nettype none

module pic_host_controller #(
    parameter int PULSE_W = 2,
    parameter int GAP_W   = 1
) (
    input  wire        clk,
    input  wire        reset,
    input  wire        init_start,
    input  wire  [7:0] icw1,
    input  wire  [7:0] icw2,
    input  wire  [7:0] icw3,
    input  wire  [7:0] icw4,
    input  wire        int_enable,
    input  wire        host_req,
    input  wire        host_rd,
    input  wire        host_a0,
    input  wire  [7:0] host_wdata,
    output logic       host_ack,
    output logic [7:0] host_rdata,
    output logic       init_done,
    output logic       busy,
    output logic [7:0] vector,
    output logic       vector_valid,
    pic_host_controller_if.master bus
);

    localparam int MAXC = (PULSE_W > GAP_W + 1) ? PULSE_W : GAP_W + 1;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic [2:0] {
        IDLE, SETUP, STROBE, HOLD, GAP, INTA1, INTA_GAP, INTA2
    } state_t;

    state_t          state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [1:0]      step, step_n;
    logic            init_act, init_act_n, init_done_n;
    logic            acc_rd, acc_rd_n, acc_a0, acc_a0_n, acc_host, acc_host_n;
    logic [7:0]      acc_data, acc_data_n;
    logic [7:0]      icw1_r, icw2_r, icw3_r, icw4_r;
    logic [2:0]      ns;
    logic [7:0]      next_word;
    logic            finish;
    logic            last;
    logic            in_bus;

    assign last = (cnt == CW'(1));

    function automatic logic [CW-1:0] dur(input state_t s);
        case (s)
            STROBE, INTA1, INTA2: dur = CW'(PULSE_W);
            INTA_GAP:             dur = CW'(GAP_W + 1);
            GAP:                  dur = CW'(GAP_W);
            SETUP, HOLD:          dur = CW'(1);
            default:              dur = '0;
        endcase
    endfunction

    // {more words pending, index of next ICW}: ICW3 only in cascade, ICW4 only if requested
    function automatic logic [2:0] next_step(input logic [1:0] s, input logic [7:0] c1);
        case (s)
            2'd0:    next_step = 3'b1_01;
            2'd1:    next_step = !c1[1] ? 3'b1_10 : (c1[0] ? 3'b1_11 : 3'b0_00);
            2'd2:    next_step = c1[0] ? 3'b1_11 : 3'b0_00;
            default: next_step = 3'b0_00;
        endcase
    endfunction

    always_comb begin
        state_n     = state;
        step_n      = step;
        init_act_n  = init_act;
        init_done_n = init_done;
        acc_rd_n    = acc_rd;
        acc_a0_n    = acc_a0;
        acc_host_n  = acc_host;
        acc_data_n  = acc_data;
        finish      = 1'b0;
        ns          = next_step(step, icw1_r);
        case (ns[1:0])
            2'd1:    next_word = icw2_r;
            2'd2:    next_word = icw3_r;
            2'd3:    next_word = icw4_r;
            default: next_word = icw1_r | 8'h10;
        endcase

        case (state)
            IDLE: begin
                if (init_start) begin
                    state_n     = SETUP;
                    init_act_n  = 1'b1;
                    init_done_n = 1'b0;
                    step_n      = 2'd0;
                    acc_rd_n    = 1'b0;
                    acc_a0_n    = 1'b0;
                    acc_host_n  = 1'b0;
                    acc_data_n  = icw1 | 8'h10;
                end else if (bus.pic_int && int_enable && init_done) begin
                    state_n = INTA1;
                end else if (host_req && init_done) begin
                    state_n    = SETUP;
                    acc_rd_n   = host_rd;
                    acc_a0_n   = host_a0;
                    acc_host_n = 1'b1;
                    acc_data_n = host_wdata;
                end
            end
            SETUP:    state_n = STROBE;
            STROBE:   if (last) state_n = HOLD;
            HOLD:     if (GAP_W == 0) finish = 1'b1; else state_n = GAP;
            GAP:      if (last) finish = 1'b1;
            INTA1:    if (last) state_n = INTA_GAP;
            INTA_GAP: if (last) state_n = INTA2;
            INTA2:    if (last) state_n = (GAP_W == 0) ? IDLE : GAP;
            default:  state_n = IDLE;
        endcase

        // init writes chain straight into the next SETUP so arbitration cannot split them
        if (finish) begin
            if (init_act && ns[2]) begin
                state_n    = SETUP;
                step_n     = ns[1:0];
                acc_rd_n   = 1'b0;
                acc_a0_n   = 1'b1;
                acc_host_n = 1'b0;
                acc_data_n = next_word;
            end else begin
                state_n = IDLE;
                if (init_act) begin
                    init_act_n  = 1'b0;
                    init_done_n = 1'b1;
                end
            end
        end

        if (state_n == IDLE)       cnt_n = '0;
        else if (state_n != state) cnt_n = dur(state_n);
        else                       cnt_n = cnt - CW'(1);

        in_bus = (state_n == SETUP) || (state_n == STROBE) || (state_n == HOLD);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= IDLE;
            cnt              <= '0;
            step             <= 2'd0;
            init_act         <= 1'b0;
            init_done        <= 1'b0;
            acc_rd           <= 1'b0;
            acc_a0           <= 1'b0;
            acc_host         <= 1'b0;
            acc_data         <= 8'h00;
            icw1_r           <= 8'h00;
            icw2_r           <= 8'h00;
            icw3_r           <= 8'h00;
            icw4_r           <= 8'h00;
            bus.pic_cs_n     <= 1'b1;
            bus.pic_wr_n     <= 1'b1;
            bus.pic_rd_n     <= 1'b1;
            bus.pic_inta_n   <= 1'b1;
            bus.pic_a0       <= 1'b0;
            bus.pic_data_oe  <= 1'b0;
            bus.pic_data_out <= 8'h00;
            host_ack         <= 1'b0;
            host_rdata       <= 8'h00;
            vector           <= 8'h00;
            vector_valid     <= 1'b0;
            busy             <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            step      <= step_n;
            init_act  <= init_act_n;
            init_done <= init_done_n;
            acc_rd    <= acc_rd_n;
            acc_a0    <= acc_a0_n;
            acc_host  <= acc_host_n;
            acc_data  <= acc_data_n;
            if (state == IDLE && init_start) begin
                icw1_r <= icw1;
                icw2_r <= icw2;
                icw3_r <= icw3;
                icw4_r <= icw4;
            end
            bus.pic_cs_n     <= !in_bus;
            bus.pic_wr_n     <= !((state_n == STROBE) && !acc_rd_n);
            bus.pic_rd_n     <= !((state_n == STROBE) && acc_rd_n);
            bus.pic_inta_n   <= !((state_n == INTA1) || (state_n == INTA2));
            bus.pic_a0       <= in_bus && acc_a0_n;
            bus.pic_data_oe  <= in_bus && !acc_rd_n;
            bus.pic_data_out <= (in_bus && !acc_rd_n) ? acc_data_n : 8'h00;
            host_ack         <= (state_n == HOLD) && acc_host_n;
            if (state == STROBE && last && acc_rd)
                host_rdata <= bus.pic_data_in;
            vector_valid     <= (state == INTA2) && last;
            if (state == INTA2 && last)
                vector <= bus.pic_data_in;
            busy             <= (state_n != IDLE);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_pic_host_controller.sv
// ============================================================================
// tb_pic_host_controller : scoreboard bench with a PIC bus model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_pic_host_controller;
    localparam int PULSE_W = 2;
    localparam int GAP_W   = 1;
    localparam int ACC_LEN = PULSE_W + 2 + GAP_W;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       init_start = 1'b0;
    logic [7:0] icw1 = 8'h00, icw2 = 8'h00, icw3 = 8'h00, icw4 = 8'h00;
    logic       int_enable = 1'b1;
    logic       host_req = 1'b0, host_rd = 1'b0, host_a0 = 1'b0;
    logic [7:0] host_wdata = 8'h00;
    logic       host_ack, init_done, busy, vector_valid;
    logic [7:0] host_rdata, vector;

    pic_host_controller_if bus ();

    pic_host_controller #(.PULSE_W(PULSE_W), .GAP_W(GAP_W)) dut (
        .clk(clk), .reset(reset), .init_start(init_start),
        .icw1(icw1), .icw2(icw2), .icw3(icw3), .icw4(icw4),
        .int_enable(int_enable), .host_req(host_req), .host_rd(host_rd),
        .host_a0(host_a0), .host_wdata(host_wdata), .host_ack(host_ack),
        .host_rdata(host_rdata), .init_done(init_done), .busy(busy),
        .vector(vector), .vector_valid(vector_valid), .bus(bus)
    );

    always #5 clk = ~clk;

    int compared = 0;
    int mismatched = 0;

    task automatic chk(input string name, input int act, input int exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Scoreboard queues: {a0,data} writes, a0 of reads, {is_read,rdata} acks, vectors
    logic [8:0] exp_wr[$];
    logic       exp_rd[$];
    logic [8:0] exp_ack[$];
    logic [7:0] exp_vec[$];

    // PIC model: returns the vector only during the second INTA pulse
    logic [7:0] rd_val = 8'h00, vec_val = 8'h00;
    int inta_pulses = 0;
    assign bus.pic_data_in = !bus.pic_inta_n ? (inta_pulses[0] ? vec_val : 8'hEE) : rd_val;

    int  cs_len = 0, wr_len = 0, rd_len = 0, inta_len = 0, gap_len = 0;
    int  ack_count = 0, inta_total = 0;
    logic wr_a0, wr_oe, wr_cs, rd_a0, rd_oe, rd_cs, inta_quiet;
    logic [7:0] wr_d;
    logic vec_seen = 1'b0;

    always @(negedge clk) begin
        logic [8:0] e;
        if (reset) begin
            cs_len = 0; wr_len = 0; rd_len = 0; inta_len = 0; gap_len = 0; inta_pulses = 0;
        end else begin
            if (!bus.pic_cs_n) cs_len++;
            else if (cs_len != 0) begin chk("cs_len", cs_len, PULSE_W + 2); cs_len = 0; end

            if (!bus.pic_wr_n) begin
                wr_len++; wr_a0 = bus.pic_a0; wr_d = bus.pic_data_out;
                wr_oe = bus.pic_data_oe; wr_cs = bus.pic_cs_n;
            end else if (wr_len != 0) begin
                if (exp_wr.size() == 0) chk("unexpected_write", 1, 0);
                else begin
                    e = exp_wr.pop_front();
                    chk("wr_a0", wr_a0, e[8]);
                    chk("wr_data", wr_d, e[7:0]);
                end
                chk("wr_len", wr_len, PULSE_W);
                chk("wr_oe", wr_oe, 1);
                chk("wr_cs_n", wr_cs, 0);
                wr_len = 0;
            end

            if (!bus.pic_rd_n) begin
                rd_len++; rd_a0 = bus.pic_a0; rd_oe = bus.pic_data_oe; rd_cs = bus.pic_cs_n;
            end else if (rd_len != 0) begin
                if (exp_rd.size() == 0) chk("unexpected_read", 1, 0);
                else chk("rd_a0", rd_a0, exp_rd.pop_front());
                chk("rd_len", rd_len, PULSE_W);
                chk("rd_oe", rd_oe, 0);
                chk("rd_cs_n", rd_cs, 0);
                rd_len = 0;
            end

            if (!bus.pic_inta_n) begin
                if (inta_len == 0) begin
                    inta_quiet = 1'b1;
                    if (inta_pulses[0]) chk("inta_gap", gap_len, GAP_W + 1);
                end
                inta_len++;
                inta_quiet &= bus.pic_cs_n & bus.pic_wr_n & bus.pic_rd_n & !bus.pic_data_oe;
            end else if (inta_len != 0) begin
                chk("inta_len", inta_len, PULSE_W);
                chk("inta_quiet", inta_quiet, 1);
                inta_pulses++; inta_total++;
                inta_len = 0; gap_len = 1;
            end else if (inta_pulses[0]) gap_len++;

            if (host_ack) begin
                ack_count++;
                if (exp_ack.size() == 0) chk("unexpected_ack", 1, 0);
                else begin
                    e = exp_ack.pop_front();
                    if (e[8]) chk("host_rdata", host_rdata, e[7:0]);
                end
            end

            if (vector_valid) begin
                vec_seen = 1'b1;
                if (exp_vec.size() == 0) chk("unexpected_vector", 1, 0);
                else chk("vector", vector, exp_vec.pop_front());
            end
        end
    end

    // Reference model of the init word sequence; returns the number of writes
    function automatic int push_init(input logic [7:0] a, b, c, d);
        int n = 2;
        exp_wr.push_back({1'b0, a | 8'h10});
        exp_wr.push_back({1'b1, b});
        if (a[1] == 1'b0) begin exp_wr.push_back({1'b1, c}); n++; end
        if (a[0] == 1'b1) begin exp_wr.push_back({1'b1, d}); n++; end
        return n;
    endfunction

    task automatic wait_idle();
        int k = 0;
        while (busy && k < 100) begin @(negedge clk); k++; end
        if (k >= 100) chk("idle_timeout", 1, 0);
    endtask

    task automatic do_init(input logic [7:0] a, b, c, d);
        int n, k;
        @(negedge clk); wait_idle();
        n = push_init(a, b, c, d);
        init_start = 1'b1; icw1 = a; icw2 = b; icw3 = c; icw4 = d;
        @(negedge clk); init_start = 1'b0; k = 1;
        chk("init_done_cleared", init_done, 0);
        while (!init_done && k < 400) begin @(negedge clk); k++; end
        chk("init_done_latency", k, n * ACC_LEN + 1);
    endtask

    task automatic host_access(input logic rd, a0, input logic [7:0] wd, rv);
        int k = 0;
        @(negedge clk); wait_idle();
        if (rd) begin exp_rd.push_back(a0); exp_ack.push_back({1'b1, rv}); end
        else begin exp_wr.push_back({a0, wd}); exp_ack.push_back({1'b0, 8'h00}); end
        rd_val = rv; host_rd = rd; host_a0 = a0; host_wdata = wd; host_req = 1'b1;
        while (!host_ack && k < 100) begin @(negedge clk); k++; end
        host_req = 1'b0;
        chk("ack_latency", k, PULSE_W + 2);
    endtask

    task automatic do_inta(input logic [7:0] v);
        int k;
        @(negedge clk); wait_idle();
        exp_vec.push_back(v); vec_val = v; bus.pic_int = 1'b1;
        @(negedge clk); bus.pic_int = 1'b0; k = 1;
        while (!vector_valid && k < 100) begin @(negedge clk); k++; end
        chk("vector_latency", k, 2 * PULSE_W + GAP_W + 2);
    endtask

    initial begin
        int k, n0;
        bus.pic_int = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_cs_n", bus.pic_cs_n, 1);   chk("rst_wr_n", bus.pic_wr_n, 1);
        chk("rst_rd_n", bus.pic_rd_n, 1);   chk("rst_inta_n", bus.pic_inta_n, 1);
        chk("rst_oe", bus.pic_data_oe, 0);  chk("rst_a0", bus.pic_a0, 0);
        chk("rst_init_done", init_done, 0); chk("rst_busy", busy, 0);
        chk("rst_vector", vector, 0);       chk("rst_rdata", host_rdata, 0);
        reset = 1'b0;

        do_init(8'h13, 8'h20, 8'hA5, 8'h01);
        do_init(8'h01, 8'h40, 8'h04, 8'h1D);
        do_init(8'h12, 8'h68, 8'h77, 8'h55);
        repeat (3) do_init(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));

        host_access(1'b1, 1'b0, 8'h00, 8'h5A);
        do_inta(8'h23);

        repeat (24) begin
            if ($urandom_range(0, 3) == 0) do_inta(8'($urandom));
            else host_access(1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom));
        end

        // masked interrupt must not start an acknowledge
        @(negedge clk); wait_idle();
        n0 = inta_total; int_enable = 1'b0; bus.pic_int = 1'b1;
        repeat (10) @(negedge clk);
        bus.pic_int = 1'b0; int_enable = 1'b1;
        chk("inta_masked", inta_total, n0);

        // INT and host request together: acknowledge wins
        @(negedge clk); wait_idle();
        exp_vec.push_back(8'h3C); vec_val = 8'h3C;
        exp_wr.push_back({1'b1, 8'h0B}); exp_ack.push_back({1'b0, 8'h00});
        vec_seen = 1'b0; bus.pic_int = 1'b1;
        host_rd = 1'b0; host_a0 = 1'b1; host_wdata = 8'h0B; host_req = 1'b1;
        @(negedge clk); bus.pic_int = 1'b0; k = 0;
        while (!host_ack && k < 100) begin @(negedge clk); k++; end
        host_req = 1'b0;
        chk("inta_before_host", vec_seen, 1);

        // host request during init stalls until init completes
        @(negedge clk); wait_idle();
        void'(push_init(8'h13, 8'h08, 8'h00, 8'h03));
        exp_wr.push_back({1'b0, 8'h66}); exp_ack.push_back({1'b0, 8'h00});
        init_start = 1'b1; icw1 = 8'h13; icw2 = 8'h08; icw3 = 8'h00; icw4 = 8'h03;
        @(negedge clk); init_start = 1'b0;
        host_rd = 1'b0; host_a0 = 1'b0; host_wdata = 8'h66; host_req = 1'b1; k = 0;
        while (!host_ack && k < 200) begin @(negedge clk); k++; end
        host_req = 1'b0;
        chk("ack_after_init", init_done, 1);
        chk("stall_latency", k, 3 * ACC_LEN + PULSE_W + 2);

        // async reset in the middle of a write strobe
        @(negedge clk); wait_idle();
        n0 = ack_count;
        host_rd = 1'b0; host_a0 = 1'b1; host_wdata = 8'hC3; host_req = 1'b1; k = 0;
        while (bus.pic_wr_n && k < 100) begin @(negedge clk); k++; end
        chk("reached_strobe", bus.pic_wr_n, 0);
        #1 reset = 1'b1;
        #1;
        chk("arst_wr_n", bus.pic_wr_n, 1); chk("arst_cs_n", bus.pic_cs_n, 1);
        chk("arst_oe", bus.pic_data_oe, 0); chk("arst_init_done", init_done, 0);
        chk("arst_busy", busy, 0);
        host_req = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (12) @(negedge clk);
        chk("no_ack_after_reset", ack_count, n0);
        chk("init_done_stays_low", init_done, 0);

        chk("wr_queue_empty", exp_wr.size(), 0);
        chk("rd_queue_empty", exp_rd.size(), 0);
        chk("ack_queue_empty", exp_ack.size(), 0);
        chk("vec_queue_empty", exp_vec.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end
endmodule

`default_nettype wire

// File: doc/pic_host_controller.md
# pic_host_controller

CPU-side bus master for the 8259-compatible PIC: it drives the PIC's chip-select, read/write strobes, A0 and data bus, and it answers the PIC's INT output with the two-pulse INTA acknowledge sequence. It runs the ICW1–ICW4 initialisation sequence, performs single host-requested OCW writes and status reads, and captures the interrupt vector that the PIC drives during the second INTA pulse. It sits between the host core and the PIC top level; the top level ties `pic_data_out`/`pic_data_oe`/`pic_data_in` to the bidirectional data bus.

## Interface
- PULSE_W, 2, cycles a strobe (`pic_wr_n`, `pic_rd_n`, `pic_inta_n`) is held low; must be ≥1
- GAP_W, 1, idle cycles after each completed access or INTA sequence; must be ≥0

- clk  in  1  single clock; all logic is rising-edge
- reset  in  1  asynchronous, active-high reset
- init_start  in  1  one-cycle pulse: latch ICW inputs and run initialisation
- icw1, icw2, icw3, icw4  in  8 each  initialisation words, sampled on `init_start`
- int_enable  in  1  allows INTA sequences once `init_done` is high
- host_req  in  1  level request for one access; held until `host_ack`
- host_rd  in  1  1 = read, 0 = write; stable while `host_req` is high
- host_a0  in  1  A0 value for the access
- host_wdata  in  8  write data
- host_ack  out  1  one-cycle completion pulse
- host_rdata  out  8  read data; valid with `host_ack` and held until the next read
- init_done  out  1  initialisation is complete
- busy  out  1  state is not IDLE
- vector  out  8  last captured vector
- vector_valid  out  1  one-cycle pulse when `vector` updates
- pic_int  in  1  INT from the PIC
- pic_cs_n, pic_wr_n, pic_rd_n, pic_inta_n  out  1 each  active-low PIC controls
- pic_a0  out  1  PIC A0
- pic_data_out  out  8  data driven to the PIC
- pic_data_oe  out  1  data bus drive enable
- pic_data_in  in  8  data from the PIC

## Operation
- **States:** IDLE, SETUP, STROBE, HOLD, GAP, INTA1, INTA_GAP, INTA2.
- **Bus access:** SETUP (1 cycle), then STROBE (PULSE_W cycles), then HOLD (1 cycle), then GAP (GAP_W cycles), then back to IDLE.
  - `pic_cs_n`, `pic_a0` and (for writes) `pic_data_out` and `pic_data_oe` are asserted from SETUP through HOLD.
  - `pic_wr_n` or `pic_rd_n` is low only in STROBE.
  - Reads register `pic_data_in` on the final STROBE edge.
  - `host_ack` pulses in the HOLD cycle for host accesses only.
- **Initialisation:** `init_start` in IDLE latches the four ICWs and clears `init_done`. The block then issues the following writes in order:
  - ICW1 with A0=0 and bit 4 forced to 1.
  - ICW2 with A0=1.
  - ICW3 with A0=1, only if ICW1[1]=0 (cascade mode).
  - ICW4 with A0=1, only if ICW1[0]=1.
  - `init_done` rises in the cycle after the last write's GAP ends.
  - `init_start` is ignored when the state is not IDLE.
- **Arbitration in IDLE**, checked in this order:
  1. `init_start`
  2. `pic_int && int_enable && init_done` → INTA
  3. `host_req` → access
  - Host requests wait while initialisation has not completed.
- **INTA sequence:**
  - INTA1: `pic_inta_n` low for PULSE_W cycles.
  - INTA_GAP: `pic_inta_n` high for GAP_W+1 cycles.
  - INTA2: `pic_inta_n` low for PULSE_W cycles; `pic_data_in` is registered into `vector` on the final INTA2 edge.
  - `vector_valid` pulses in the next cycle, and GAP follows.
  - `pic_cs_n`, `pic_wr_n`, `pic_rd_n` stay high and `pic_data_oe` stays 0 throughout.
  - Once INTA1 has begun, the sequence always completes, even if `pic_int` drops.
- **Counters:** one down-counter of width $clog2(max(PULSE_W, GAP_W+1)+1). The counter is loaded on each state entry, and the state exits when the counter reaches 1 (GAP with GAP_W=0 is skipped).

## Timing
- **Reset values:**
  - `pic_cs_n`, `pic_wr_n`, `pic_rd_n`, `pic_inta_n` = 1.
  - `pic_a0`, `pic_data_oe`, `pic_data_out`, `host_ack`, `host_rdata`, `vector`, `vector_valid`, `init_done`, `busy` = 0.
  - State = IDLE.
  - Reset asserted mid-access or mid-INTA returns all of the above immediately and abandons the operation. `init_done` stays 0 until a new `init_start`.
- **Single access length:** PULSE_W+2+GAP_W cycles (5 cycles with defaults).
  - `host_req` sampled at edge n: SETUP is cycle n+1, `host_ack` is in cycle n+PULSE_W+2.
- **INTA timing:** `pic_int` sampled at edge n gives:
  - `pic_inta_n` low in cycles n+1 to n+PULSE_W.
  - High for GAP_W+1 cycles.
  - Low again for PULSE_W cycles.
  - `vector_valid` in the following cycle (cycle n+7 with defaults).
- **Back-to-back requests:** `host_req` still high in the cycle after `host_ack` starts a new access only after GAP. The host must drop `host_req` in the cycle after `host_ack` to avoid a repeat access.
- **All outputs are registered.**

## Test plan
- **Init, single-mode ICW4 path:** `init_start` with icw1=0x13, icw2=0x20, icw4=0x01 → three writes, A0=0/1/1, data 0x13/0x20/0x01, no ICW3 write, `init_done` high after 15 cycles (defaults).
- **Init, cascade path:** icw1=0x01 (bit 4 forced, driven as 0x11) → four writes including ICW3; icw1=0x12 → two writes only.
- **Interrupt acknowledge:** `init_done` high, `pic_int` pulsed, PIC model drives 0x23 during INTA2 → two 2-cycle INTA pulses separated by 2 cycles, `vector`=0x23 with one `vector_valid` pulse; `pic_int` dropped mid-sequence still completes.
- **Host read:** `host_rd`=1, `host_a0`=0, PIC returns 0x5A → `pic_rd_n` low for 2 cycles, `pic_data_oe`=0, `host_rdata`=0x5A with `host_ack` in the 4th cycle.
- **Simultaneous INT and `host_req` in IDLE:** INTA sequence runs first, then the host access; `host_req` during initialisation is stalled until `init_done`.
- **Async reset during STROBE of a write:** all strobes go high and `pic_data_oe`=0 the same cycle, `init_done`=0, and no `host_ack` is issued.
